// File: rtl/demux16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux16_pkg
// Description : Shared types and constants for the 16-channel scan demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux16_pkg;

   localparam int NCH       = 16;   // channels behind the external mux
   localparam int SEL_W     = 4;    // select width for NCH channels
   localparam int DWELL_MIN = 3;    // shortest dwell the sampler supports

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/demux16_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : demux16_scan_if
// Description : Scan request, returned mux line and reconstructed word bundle.
//               master = controller/consumer side, slave = demux16_scan.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux16_scan_if;
   import demux16_pkg::*;

   logic             en;
   logic             y_in;
   logic [SEL_W-1:0] sel;
   logic [NCH-1:0]   q;
   logic             frame_done;
   logic             busy;

   modport master (
      output en, y_in,
      input  sel, q, frame_done, busy
   );

   modport slave (
      input  en, y_in,
      output sel, q, frame_done, busy
   );

endinterface
`default_nettype wire

// File: rtl/demux16_sampler.sv
`default_nettype none
// ============================================================================
// Module      : demux16_sampler
// Description : Produces the channel value and the end-of-dwell take strobe.
//               Build option DEMUX16_DEGLITCH_EN: value is the majority of the
//               samples at cnt = DWELL-3, DWELL-2 and DWELL-1. Otherwise the
//               value is the single sample at cnt = DWELL-1.
// Revision    : 1.0 - initial release
// ============================================================================
module demux16_sampler #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
`ifdef DEMUX16_DEGLITCH_EN
   input  logic             pck0,
   input  logic             nreset,
`endif
   input  logic [CNT_W-1:0] cnt,
   input  logic             y_in,
   output logic             value,
   output logic             take
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DWELL - 1);

   assign take = (cnt == C_LAST);

`ifdef DEMUX16_DEGLITCH_EN
   localparam logic [CNT_W-1:0] C_LOAD0 = CNT_W'(DWELL - 3);
   localparam logic [CNT_W-1:0] C_LOAD1 = CNT_W'(DWELL - 2);

   logic s0_q, s0_d;
   logic s1_q, s1_d;

   // Clear the vote at dwell start, then capture the two early samples.
   always_comb begin
      s0_d = s0_q;
      s1_d = s1_q;
      if (cnt == '0) begin
         s0_d = 1'b0;
         s1_d = 1'b0;
      end
      if (cnt == C_LOAD0) s0_d = y_in;
      if (cnt == C_LOAD1) s1_d = y_in;
   end

   // Early-sample registers.
   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         s0_q <= 1'b0;
         s1_q <= 1'b0;
      end else begin
         s0_q <= s0_d;
         s1_q <= s1_d;
      end
   end

   // The third vote is the live line at the take edge.
   assign value = (s0_q & s1_q) | (s0_q & y_in) | (s1_q & y_in);
`else
   assign value = y_in;
`endif

endmodule
`default_nettype wire

// File: rtl/demux16_scan.sv
`default_nettype none
// ============================================================================
// Module      : demux16_scan
// Description : Scan sequencer and 1-to-16 demultiplexer. Steps sel over the
//               16 channels with a DWELL-cycle hold, rebuilds the sampled
//               line into q, which updates atomically once per frame.
//               Build option DEMUX16_DEGLITCH_EN selects 3-sample majority.
// Revision    : 1.0 - initial release
// ============================================================================
module demux16_scan
   import demux16_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic           pck0,
   input  logic           nreset,
   demux16_scan_if.slave  bus
);

   localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(NCH - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NCH-2:0]   shadow_q, shadow_d;
   logic [NCH-1:0]   q_q, q_d;
   logic             frame_done_q, frame_done_d;

   logic             value;
   logic             take;

   demux16_sampler #(
      .DWELL (DWELL),
      .CNT_W (CNT_W)
   ) u_sampler (
`ifdef DEMUX16_DEGLITCH_EN
      .pck0   (pck0),
      .nreset (nreset),
`endif
      .cnt    (cnt_q),
      .y_in   (bus.y_in),
      .value  (value),
      .take   (take)
   );

   // Next-state: dwell counting, channel stepping and frame publication.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      q_d          = q_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            sel_d = '0;
            cnt_d = '0;
            if (bus.en) state_d = SCAN;
         end
         SCAN: begin
            if (take) begin
               cnt_d = '0;
               sel_d = sel_q + 1'b1;
               if (sel_q == C_SEL_LAST) begin
                  // en is only consulted here, so frames are never truncated.
                  q_d          = {value, shadow_q};
                  frame_done_d = 1'b1;
                  if (!bus.en) state_d = IDLE;
               end else begin
                  shadow_d[sel_q] = value;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any partial frame.
   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         q_q          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         q_q          <= q_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.q          = q_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = (state_q == SCAN);

endmodule
`default_nettype wire

// File: tb/tb_demux16_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux16_scan
// Description : Self-checking bench for demux16_scan, DWELL=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux16_scan;

   localparam int D  = 4;
   localparam int FL = 16 * D;

   logic        pck0;
   logic        nreset;
   logic [15:0] pat;
   logic        glitch;
   int          checks;
   int          failures;

   demux16_scan_if bus();

   demux16_scan #(
      .DWELL (D),
      .CNT_W (8)
   ) dut (
      .pck0   (pck0),
      .nreset (nreset),
      .bus    (bus)
   );

   initial pck0 = 1'b0;
   always #5 pck0 = ~pck0;

   // Model 16:1 mux with an optional forced-low glitch.
   always_comb bus.y_in = glitch ? 1'b0 : pat[bus.sel];

   typedef struct {
      logic [15:0] pat;
      logic [15:0] exp_q;
      int          drop_j;
   } vec_t;

   vec_t vecs [5];

   task automatic tick();
      @(posedge pck0);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called just after the frame's start edge; ends just after the publish edge.
   task automatic run_frame(input logic [15:0] exp_q, input logic [15:0] prev_q,
                            input int drop_j, input int glitch_j);
      logic early;
      early = 1'b0;
      chk("frame_start_sel", 32'(bus.sel), 32'd0);
      chk("frame_start_busy", 32'(bus.busy), 32'd1);
      for (int j = 0; j < FL; j++) begin
         glitch = (j == glitch_j);
         if (j == drop_j) bus.en = 1'b0;
         tick();
         if (j + 1 < FL) begin
            if (bus.frame_done) early = 1'b1;
            if ((j + 1) % D == 0) chk("sel_step", 32'(bus.sel), 32'((j + 1) / D));
            if (j + 1 == FL / 2) chk("q_hold_midframe", 32'(bus.q), 32'(prev_q));
         end
      end
      glitch = 1'b0;
      chk("frame_done_early", 32'(early), 32'd0);
      chk("frame_done_pulse", 32'(bus.frame_done), 32'd1);
      chk("q_word", 32'(bus.q), 32'(exp_q));
   endtask

   initial begin
      logic [15:0] prev;
      logic        seen;
      checks   = 0;
      failures = 0;
      pat      = 16'h0000;
      glitch   = 1'b0;
      bus.en   = 1'b0;
      nreset   = 1'b0;

      vecs[0] = '{16'hA5C3, 16'hA5C3, -1};
      vecs[1] = '{16'h0001, 16'h0001, -1};
      vecs[2] = '{16'h8000, 16'h8000, -1};
      vecs[3] = '{16'h5AF0, 16'h5AF0, -1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 6 * D};

      // Reset state
      tick(); tick();
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_sel", 32'(bus.sel), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
      nreset = 1'b1;
      tick(); tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Back-to-back frames; last vector drops en after channel 5.
      pat    = vecs[0].pat;
      bus.en = 1'b1;
      tick();
      prev = 16'h0000;
      for (int v = 0; v < 5; v++) begin
         pat = vecs[v].pat;
         run_frame(vecs[v].exp_q, prev, vecs[v].drop_j, -1);
         prev = vecs[v].exp_q;
      end
      tick();
      chk("after_drop_busy", 32'(bus.busy), 32'd0);
      chk("after_drop_fd", 32'(bus.frame_done), 32'd0);
      chk("after_drop_sel", 32'(bus.sel), 32'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("idle_stays_busy", 32'(bus.busy), 32'd0);
      chk("idle_stays_q", 32'(bus.q), 32'hFFFF);

      // Asynchronous reset during channel 9.
      pat    = 16'h1234;
      bus.en = 1'b1;
      tick();
      for (int i = 0; i < 9 * D + 2; i++) tick();
      chk("pre_rst_sel", 32'(bus.sel), 32'd9);
      #2;
      nreset = 1'b0;
      bus.en = 1'b0;
      #1;
      chk("async_rst_q", 32'(bus.q), 32'd0);
      chk("async_rst_sel", 32'(bus.sel), 32'd0);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_fd", 32'(bus.frame_done), 32'd0);
      tick(); tick();
      nreset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < FL + 16; i++) begin
         tick();
         if (bus.frame_done || bus.busy) seen = 1'b1;
      end
      chk("no_frame_after_rst", 32'(seen), 32'd0);

      // Fresh frame after reset release.
      pat    = 16'h3C96;
      bus.en = 1'b1;
      tick();
      run_frame(16'h3C96, 16'h0000, 10 * D + 1, -1);
      tick();
      chk("post_rst_busy", 32'(bus.busy), 32'd0);

      // Single glitch on channel 3.
      pat    = 16'h0008;
      bus.en = 1'b1;
      tick();
`ifdef DEMUX16_DEGLITCH_EN
      run_frame(16'h0008, 16'h3C96, 0, 3 * D + 1);
`else
      run_frame(16'h0000, 16'h3C96, 0, 3 * D + 3);
`endif
      tick();
      chk("glitch_end_busy", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
